hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the wait-cycle limit before a memory error is declared.
REQ-002 SHALL have parameter CNT_W, default 16, the stall-counter width.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 Rs1D, Rs2D  in  5  source registers in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
REQ-007 RdM, RdW  in  5  destination registers in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
REQ-009 ResultSrcE  in  3  Execute result select; the LOAD encoding marks a load.
REQ-010 PCSrcE  in  1  branch or jump taken in Execute.
REQ-011 MemReqM, MemAckM  in  1  data-memory request in Memory; memory ready/acknowledge.
REQ-012 ForwardAE, ForwardBE  out  2  operand forwarding select: 00 register file, 01 Writeback, 10 Memory.
REQ-013 StallF, StallD, StallE, StallM  out  1  hold enables for the PC and the D/E/M pipeline registers.
REQ-014 FlushD, FlushE, FlushW  out  1  bubble insertion into the D, E and W pipeline registers.
REQ-015 MemErr  out  1  sticky memory-timeout error.
REQ-016 StallCnt  out  CNT_W  count of stalled cycles.

Function
REQ-017 ForwardAE SHALL be 10 when RegWriteM && RdM!=0 && RdM==Rs1E; else 01 when RegWriteW && RdW!=0 && RdW==Rs1E; else 00. ForwardBE follows the same rule using Rs2E.
REQ-018 Forwarding SHALL be combinational with zero latency, and Memory SHALL take priority over Writeback.
REQ-019 LoadUse SHALL be asserted when ResultSrcE==LOAD && RdE!=0 && (RdE==Rs1D || RdE==Rs2D); it drives StallF=StallD=FlushE=1 for exactly that cycle.
REQ-020 When PCSrcE==1, FlushD=FlushE=1 for that cycle.
REQ-021 The memory FSM SHALL have states IDLE, WAIT and ERR.
  - IDLE->WAIT when MemReqM && !MemAckM.
  - WAIT->IDLE on MemAckM.
  - WAIT->ERR when the wait counter reaches MEM_TIMEOUT-1 without MemAckM.
  - ERR is held until RST.
REQ-022 MemStall SHALL equal (IDLE && MemReqM && !MemAckM) || (WAIT && !MemAckM) || ERR; it is combinational so the first miss cycle stalls immediately.
REQ-023 While MemStall: StallF=StallD=StallE=StallM=1 and FlushW=1, while FlushD, FlushE and LoadUse effects are suppressed so the frozen pipeline holds.
REQ-024 A request acknowledged in the same cycle (MemReqM && MemAckM in IDLE) SHALL cause zero stall cycles.
REQ-025 The wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-026 MemErr SHALL be set on entry to ERR and remain 1 until RST.
REQ-027 StallCnt SHALL increment on every cycle in which any Stall output is 1, saturating at all-ones with no wrap.
REQ-028 Branch flush and LoadUse occurring in the same cycle (no MemStall): FlushD=FlushE=1, StallF=StallD=1.

Reset
REQ-029 On RST the FSM SHALL go to IDLE, the wait counter and StallCnt to 0, and MemErr to 0, asynchronously.
REQ-030 Reset asserted mid-WAIT or in ERR SHALL abort to IDLE, after which outputs follow only the current inputs.
REQ-031 Combinational outputs (Forward*, Stall*, Flush*) SHALL have no reset value of their own beyond their dependence on FSM state.

Structure
REQ-032 A shared package hazard_pkg SHALL hold the ResultSrc LOAD encoding, the forward-select constants (FWD_RF, FWD_W, FWD_M) and the memory-FSM state enum.
REQ-033 Forwarding logic SHALL be a sub-module forward_unit, instantiated twice (A and B).

Verification
REQ-034 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; with RdM=0 -> ForwardAE=01; with Rs1E=0 and RdW=0 -> 00.
REQ-035 ResultSrcE=LOAD, RdE=7, Rs2D=7 -> one cycle with StallF=StallD=FlushE=1; with RdE=0 -> no stall.
REQ-036 MemReqM=1, MemAckM low for 3 cycles then high -> all four Stall outputs=1 and FlushW=1 for exactly 3 cycles, then FSM in IDLE and StallCnt=3.
REQ-037 MemAckM held low for 15 cycles -> MemErr=1 and stalls persist; pulse RST -> MemErr=0, StallCnt=0, state IDLE.
REQ-038 PCSrcE=1 during a memory wait -> FlushD=FlushE=0; PCSrcE=1 in the cycle after the ack -> FlushD=FlushE=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;

    // ResultSrcE encoding that marks a load in Execute
    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Data-memory handshake tracker states
    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_ERR  = 2'b10
    } mem_state_t;

    // A destination register matches a source register; x0 never matches
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [4:0]       RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [2:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MemReqM, MemAckM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt;

    // Hazard controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemErr, StallCnt
    );

    // Pipeline side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemErr, StallCnt
    );
endinterface

// File: rtl/forward_unit.sv
// Operand forwarding select for one Execute source register.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_sel_o
);

    // Memory stage holds the newer value, so it wins over Writeback
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (reg_write_m_i && reg_hit(rd_m_i, rs_e_i)) begin
            fwd_sel_o = FWD_M;
        end else if (reg_write_w_i && reg_hit(rd_w_i, rs_e_i)) begin
            fwd_sel_o = FWD_W;
        end else begin
            fwd_sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// data-memory wait/timeout handling with a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,   // consecutive unacknowledged cycles before error (>= 2)
    parameter int CNT_W       = 16
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  hz
);

    localparam int              WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    mem_state_t        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              mem_stall, load_use, any_stall;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    logic [1:0]        fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .rs_e_i        (hz.Rs1E),
        .rd_m_i        (hz.RdM),
        .rd_w_i        (hz.RdW),
        .reg_write_m_i (hz.RegWriteM),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_sel_o     (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e_i        (hz.Rs2E),
        .rd_m_i        (hz.RdM),
        .rd_w_i        (hz.RdW),
        .reg_write_m_i (hz.RegWriteM),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_sel_o     (fwd_b)
    );

    assign load_use = (hz.ResultSrcE == RESULT_SRC_LOAD) &&
                      (reg_hit(hz.RdE, hz.Rs1D) || reg_hit(hz.RdE, hz.Rs2D));
    assign wcnt_inc = wcnt_q + WCNT_W'(1);

    // Memory FSM next state; the IDLE miss cycle counts as the first miss,
    // so ERR is entered after MEM_TIMEOUT consecutive unacknowledged cycles
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_stall = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (hz.MemReqM && !hz.MemAckM) begin
                    mem_stall = 1'b1;
                    state_d   = MEM_WAIT;
                    wcnt_d    = '0;
                end else begin
                    state_d   = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                if (hz.MemAckM) begin
                    state_d = MEM_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    wcnt_d    = wcnt_inc;
                    if (wcnt_inc == WAIT_LAST) begin
                        state_d = MEM_ERR;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_ERR: begin
                mem_stall = 1'b1;
                state_d   = MEM_ERR;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Stall/flush outputs; a memory stall freezes everything and masks
    // branch and load-use effects so the frozen pipeline holds its contents
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = load_use;
            stall_d = load_use;
            flush_d = hz.PCSrcE;
            flush_e = hz.PCSrcE | load_use;
        end
    end

    assign any_stall = mem_stall | load_use;

    // State, wait counter, sticky error and saturating stall counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= MEM_IDLE;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_q | (state_d == MEM_ERR);
            if (any_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushW    = flush_w;
    assign hz.MemErr    = mem_err_q;
    assign hz.StallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// checked against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 5;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    // model state: sticky error, outstanding request, consecutive misses, stall count
    bit m_err, m_out;
    int m_miss, m_cnt;
    bit e_mstall, e_lu;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (hz.RegWriteM && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_err = 1'b0; m_out = 1'b0; m_miss = 0; m_cnt = 0;
    endtask

    // compare every output with the model for the current inputs
    task automatic check_outputs();
        logic [6:0] exp_ctl, got_ctl;
        bit st;
        e_mstall = m_err || (!hz.MemAckM && (hz.MemReqM || m_out));
        e_lu = (hz.ResultSrcE == 3'd1) && (hz.RdE != 5'd0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        st = e_mstall || e_lu;
        exp_ctl = {st, st, e_mstall, e_mstall,
                   !e_mstall && hz.PCSrcE,
                   !e_mstall && (hz.PCSrcE || e_lu),
                   e_mstall};
        got_ctl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
        check_val("fwdA", 32'(hz.ForwardAE), 32'(fwd_ref(hz.Rs1E)));
        check_val("fwdB", 32'(hz.ForwardBE), 32'(fwd_ref(hz.Rs2E)));
        check_val("ctl",  32'(got_ctl), 32'(exp_ctl));
        check_val("err",  32'(hz.MemErr), 32'(m_err));
        check_val("cnt",  32'(hz.StallCnt), 32'(m_cnt));
    endtask

    // what the coming clock edge does to the model
    task automatic model_advance();
        if (!m_err) begin
            if (e_mstall) begin
                m_miss++;
                m_out = 1'b1;
                if (m_miss >= MEM_TIMEOUT) m_err = 1'b1;
            end else begin
                m_miss = 0;
                m_out  = 1'b0;
            end
        end
        if ((e_mstall || e_lu) && m_cnt < CNT_MAX) m_cnt++;
    endtask

    // called right after a negedge with inputs already driven
    task automatic cyc();
        #1;
        check_outputs();
        model_advance();
        @(negedge CLK);
    endtask

    task automatic pulse_rst();
        #1 RST = 1'b1;
        #1;
        model_clear();
        check_val("rst_err", 32'(hz.MemErr), 32'd0);
        check_val("rst_cnt", 32'(hz.StallCnt), 32'd0);
        RST = 1'b0;
        cyc();
    endtask

    task automatic set_idle();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdE = 5'd0;
        hz.RdM = 5'd0; hz.RdW = 5'd0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.ResultSrcE = 3'd0; hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemAckM = 1'b0;
    endtask

    initial begin
        set_idle();
        model_clear();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        cyc();

        // forwarding priority
        hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
        #1 check_val("fwdA_mem", 32'(hz.ForwardAE), 32'd2);
        check_val("fwdB_mem", 32'(hz.ForwardBE), 32'd2);
        cyc();
        hz.RdM = 5'd0;
        #1 check_val("fwdA_wb", 32'(hz.ForwardAE), 32'd1);
        cyc();
        hz.Rs1E = 5'd0; hz.RdW = 5'd0;
        #1 check_val("fwdA_rf", 32'(hz.ForwardAE), 32'd0);
        cyc();

        // load-use
        set_idle();
        hz.ResultSrcE = 3'b001; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1 check_val("lu_stall", 32'({hz.StallF, hz.StallD, hz.FlushE, hz.StallE}), 32'b1110);
        cyc();
        hz.RdE = 5'd0;
        #1 check_val("lu_x0", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'b000);
        cyc();

        // load-use together with branch
        hz.RdE = 5'd7; hz.PCSrcE = 1'b1;
        #1 check_val("lu_br", 32'({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}), 32'b1111);
        cyc();

        // three-cycle memory wait
        set_idle();
        pulse_rst();
        hz.MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("mw_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW}), 32'b11111);
            cyc();
        end
        hz.MemAckM = 1'b1;
        #1 check_val("mw_ack", 32'({hz.StallF, hz.StallM, hz.FlushW}), 32'b000);
        cyc();
        hz.MemReqM = 1'b0; hz.MemAckM = 1'b0;
        #1 check_val("mw_cnt", 32'(hz.StallCnt), 32'd3);
        check_val("mw_idle", 32'(hz.StallF), 32'd0);
        cyc();

        // same-cycle ack costs nothing
        hz.MemReqM = 1'b1; hz.MemAckM = 1'b1;
        #1 check_val("hit_nostall", 32'(hz.StallF), 32'd0);
        cyc();

        // branch during wait is masked, branch after ack flushes
        hz.MemReqM = 1'b1; hz.MemAckM = 1'b0; hz.PCSrcE = 1'b1;
        #1 check_val("br_in_wait", 32'({hz.FlushD, hz.FlushE}), 32'b00);
        cyc();
        hz.MemAckM = 1'b1; hz.PCSrcE = 1'b0;
        cyc();
        hz.MemReqM = 1'b0; hz.MemAckM = 1'b0; hz.PCSrcE = 1'b1;
        #1 check_val("br_after_ack", 32'({hz.FlushD, hz.FlushE}), 32'b11);
        cyc();

        // timeout, sticky error, counter saturation, reset recovery
        set_idle();
        pulse_rst();
        hz.MemReqM = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) cyc();
        #1 check_val("err_not_yet", 32'(hz.MemErr), 32'd0);
        cyc();
        #1 check_val("err_set", 32'(hz.MemErr), 32'd1);
        hz.MemReqM = 1'b0; hz.MemAckM = 1'b1;
        cyc();
        #1 check_val("err_stall", 32'({hz.StallF, hz.StallE, hz.FlushW}), 32'b111);
        for (int i = 0; i < 20; i++) cyc();
        #1 check_val("cnt_sat", 32'(hz.StallCnt), 32'(CNT_MAX));
        cyc();
        hz.MemAckM = 1'b0;
        pulse_rst();
        #1 check_val("post_rst_idle", 32'(hz.StallF), 32'd0);
        check_val("post_rst_err", 32'(hz.MemErr), 32'd0);
        cyc();

        // random traffic with periodic resets (some land mid-wait)
        for (int i = 0; i < 800; i++) begin
            hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
            hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
            hz.RdE  = 5'($urandom_range(0, 7)); hz.RdM  = 5'($urandom_range(0, 7));
            hz.RdW  = 5'($urandom_range(0, 7));
            hz.RegWriteM = 1'($urandom_range(0, 1)); hz.RegWriteW = 1'($urandom_range(0, 1));
            hz.ResultSrcE = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom_range(0, 7));
            hz.PCSrcE  = ($urandom_range(0, 3) == 0);
            hz.MemReqM = 1'($urandom_range(0, 1));
            hz.MemAckM = ($urandom_range(0, 9) < 7);
            if ((i % 60) == 59) pulse_rst();
            else cyc();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
